mod_n_counter: RTL and testbench
================================

// Module: mod_n_counter
// PURPOSE
//   Parametrised modulo-N up/down counter with synchronous load.
//   It generalises the fixed mod-6 counter to any modulus and width, and adds a
//   direction control, a preset load and a same-cycle terminal-count output for
//   cascading (e.g. mod-10/mod-6 digit chains in clock and timer datapaths).
//   It also provides a registered one-cycle carry/borrow pulse.
// PARAMETERS
//   WIDTH    4  width of count in bits
//   MODULUS  6  count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
// PORTS
//   clk       input   1      rising-edge clock, single clock domain
//   rst       input   1      synchronous, active-high reset
//   en        input   1      count enable; one step per clk while high
//   up        input   1      direction: 1 = increment, 0 = decrement
//   load      input   1      synchronous load strobe
//   load_val  input   WIDTH  value to load
//   count     output  WIDTH  registered count value
//   co        output  1      registered carry (up) / borrow (down), one-cycle pulse
//   tc        output  1      combinational terminal count, for cascade enable
// BEHAVIOUR
//   - Reset values: count = 0, co = 0. Reset is sampled only on posedge clk.
//   - Priority on each posedge clk: rst > load > en.
//   - rst=1: count <= 0, co <= 0, regardless of load or en.
//   - load=1 (rst=0):
//       count <= load_val if load_val < MODULUS, else MODULUS-1 (saturate).
//       co <= 0. en and up are ignored in that cycle.
//   - en=1, up=1: count==MODULUS-1 -> count <= 0, co <= 1; else count+1, co <= 0.
//   - en=1, up=0: count==0 -> count <= MODULUS-1, co <= 1; else count-1, co <= 0.
//   - en=0 (no rst, no load): count holds and co <= 0.
//       co is strictly a one-cycle pulse; it never stretches while idle.
//   - co latency: high in the cycle immediately after the wrapping edge,
//     i.e. together with count=0 (up) or count=MODULUS-1 (down).
//   - tc = en & (up ? count==MODULUS-1 : count==0).
//       No register; it goes high in the same cycle as the wrap condition.
//       Drive the next stage's en from this stage's tc.
//       tc ignores rst and load; the consumer also resets or loads in that case.
//   - Direction may change on any cycle. The step uses the up value sampled at
//     that edge. There is no pipeline and no hidden state beyond count and co.
//   - Arithmetic is done in WIDTH bits. count never leaves 0..MODULUS-1, and
//     values at or above MODULUS are unreachable.
//     When MODULUS==2**WIDTH, natural wrap equals the modulo wrap; compare
//     against MODULUS-1 explicitly, not against the overflow.
//   - Reset mid-count: the next cycle shows count=0, co=0. A pending wrap pulse
//     is discarded.
// TESTING
//   1 rst then en=1,up=1 for 7 clks (defaults)
//       -> count 1,2,3,4,5,0,1; co=1 only in the cycle count=0;
//          tc=1 while count=5.
//   2 en=1,up=0 from count=0
//       -> count 5,4,3; co=1 in the cycle count first =5; tc=1 while count=0.
//   3 load=1,load_val=3 with en=1 -> count=3, co=0;
//     load_val=9 -> count=5 (saturated).
//   4 wrap to 0 (co=1), then en=0 for 3 clks
//       -> count holds at 0, co drops to 0 after one cycle.
//   5 rst=1 asserted together with load=1 and en=1 at count=5 -> count=0, co=0.
//   6 cascade MODULUS=10 into MODULUS=6, low en=1, high en=low tc, 60 clks
//       -> pair reads 0..59 then 00; high co pulses once.

Source files
------------

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with synchronous load and saturation of
// out-of-range load values. It has two outputs for cascading: co is a
// registered one-cycle carry/borrow pulse, and tc is a combinational
// terminal count meant to drive the next stage's enable.
// Legal parameters: 2 <= MODULUS <= 2**WIDTH.
module mod_n_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             co,
   output logic             tc
);

   // Highest legal count. The wrap test compares against this value, never
   // against a WIDTH-bit overflow, so MODULUS == 2**WIDTH behaves the same
   // as any other modulus.
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   // The modulus is one bit wider than the count, so it stays representable
   // when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic             at_last;
   logic             at_zero;
   logic             wrap;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_sat;

   // Decode the terminal conditions, the next value for a step, and the saturated load value.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      at_last  = 1'b0;
      at_zero  = 1'b0;
      wrap     = 1'b0;
      step_val = count;
      load_sat = LAST;

      at_last = (count == LAST);
      at_zero = (count == '0);

      if (up) begin
         wrap     = at_last;
         step_val = at_last ? '0 : count + ONE;
      end else begin
         wrap     = at_zero;
         step_val = at_zero ? LAST : count - ONE;
      end

      if ({1'b0, load_val} < MOD_EXT) begin
         load_sat = load_val;
      end
   end

   // Terminal count is decoded in the same cycle. It ignores rst and load,
   // because the downstream stage sees the same rst and load.
   assign tc = en & wrap;

   // Register update with priority rst > load > en. co is high only after a wrapping step.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
      if (rst) begin
         count <= '0;
         co    <= 1'b0;
      end else if (load) begin
         count <= load_sat;
         co    <= 1'b0;
      end else if (en) begin
         count <= step_val;
         co    <= wrap;
      end else begin
         co    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_n_counter.sv
// Testbench for mod_n_counter.
// Main instance: default mod-6 counter.
// Full-range instance: WIDTH=3, MODULUS=8, driven by the same inputs.
// Cascade: mod-10 stage feeding a mod-6 stage.
// Each stimulus cycle pushes the expected count/co of both the main and
// full-range instances to a queue. A monitor pops and compares them after
// each rising edge.
module tb_mod_n_counter;

   typedef struct packed {
      logic [3:0] count;
      logic       co;
      logic [2:0] fcount;
      logic       fco;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       co;
   logic       tc;
   logic [2:0] f_cnt;
   logic       f_co;
   logic       f_tc;

   logic       c_rst;
   logic       c_en;
   logic [3:0] lo_cnt;
   logic       lo_co;
   logic       lo_tc;
   logic [2:0] hi_cnt;
   logic       hi_co;
   logic       hi_tc;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model state.
   int   m_count = 0;
   bit   m_co    = 0;
   int   f_count = 0;
   bit   f_cob   = 0;
   bit   exp_tc;
   bit   exp_ftc;

   mod_n_counter u_dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(count), .co(co), .tc(tc)
   );

   mod_n_counter #(.WIDTH(3), .MODULUS(8)) u_full (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val[2:0]), .count(f_cnt), .co(f_co), .tc(f_tc)
   );

   mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
      .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0),
      .load_val(4'd0), .count(lo_cnt), .co(lo_co), .tc(lo_tc)
   );

   mod_n_counter #(.WIDTH(3), .MODULUS(6)) u_hi (
      .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .load(1'b0),
      .load_val(3'd0), .count(hi_cnt), .co(hi_co), .tc(hi_tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: pop one expectation per stimulus cycle and compare after the edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (count !== mon_e.count) begin
            errors++;
            $display("FAIL sb_count: got %0d expected %0d at %0t", count, mon_e.count, $time);
         end
         checks++;
         if (co !== mon_e.co) begin
            errors++;
            $display("FAIL sb_co: got %b expected %b at %0t", co, mon_e.co, $time);
         end
         checks++;
         if (f_cnt !== mon_e.fcount) begin
            errors++;
            $display("FAIL sb_full_count: got %0d expected %0d at %0t", f_cnt, mon_e.fcount, $time);
         end
         checks++;
         if (f_co !== mon_e.fco) begin
            errors++;
            $display("FAIL sb_full_co: got %b expected %b at %0t", f_co, mon_e.fco, $time);
         end
      end
   end

   function automatic void model_next(input int md, input int c, input bit r, input bit l,
                                      input bit e, input bit u, input int lv,
                                      output int nc, output bit nco);
      nc  = c;
      nco = 1'b0;
      if (r) begin
         nc = 0;
      end else if (l) begin
         nc = (lv < md) ? lv : md - 1;
      end else if (e) begin
         if (u) begin
            nc  = (c + 1) % md;
            nco = (c + 1 >= md);
         end else begin
            nc  = (c + md - 1) % md;
            nco = (c == 0);
         end
      end
   endfunction

   // Drive one cycle of stimulus (called at a falling edge) and push the expected post-edge state.
   task automatic apply(input bit r, input bit l, input bit e, input bit u, input logic [3:0] lv);
      exp_t x;
      rst = r; load = l; en = e; up = u; load_val = lv;
      exp_tc  = e & (u ? (m_count == 5) : (m_count == 0));
      exp_ftc = e & (u ? (f_count == 7) : (f_count == 0));
      model_next(6, m_count, r, l, e, u, int'(lv), m_count, m_co);
      model_next(8, f_count, r, l, e, u, int'(lv[2:0]), f_count, f_cob);
      x.count  = m_count[3:0];
      x.co     = m_co;
      x.fcount = f_count[2:0];
      x.fco    = f_cob;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      apply(1, 0, 0, 1, 4'd0);
      @(negedge clk);
      apply(1, 1, 1, 1, 4'd3);
      #1;
      checks++;
      if (tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_tc: got %b expected 0", tc);
      end
      @(posedge clk); #2;
      checks++;
      if (count !== 4'd0 || co !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got count=%0d co=%b expected count=0 co=0", count, co);
      end
      @(negedge clk);
   endtask

   task automatic test_count_up();
      int exp_cnt [7];
      bit exp_co  [7];
      bit exp_t_l [7];
      exp_cnt = '{1, 2, 3, 4, 5, 0, 1};
      exp_co  = '{0, 0, 0, 0, 0, 1, 0};
      exp_t_l = '{0, 0, 0, 0, 0, 1, 0};
      apply(1, 0, 0, 1, 4'd0);
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         apply(0, 0, 1, 1, 4'd0);
         #1;
         checks++;
         if (tc !== exp_t_l[i]) begin
            errors++;
            $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, exp_t_l[i]);
         end
         @(posedge clk); #2;
         checks++;
         if (count !== 4'(exp_cnt[i]) || co !== exp_co[i]) begin
            errors++;
            $display("FAIL up_step[%0d]: got count=%0d co=%b expected count=%0d co=%b",
                     i, count, co, exp_cnt[i], exp_co[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_count_down();
      int exp_cnt [3];
      bit exp_co  [3];
      bit exp_t_l [3];
      exp_cnt = '{5, 4, 3};
      exp_co  = '{1, 0, 0};
      exp_t_l = '{1, 0, 0};
      apply(1, 0, 0, 0, 4'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 1, 0, 4'd0);
         #1;
         checks++;
         if (tc !== exp_t_l[i]) begin
            errors++;
            $display("FAIL down_tc[%0d]: got %b expected %b", i, tc, exp_t_l[i]);
         end
         @(posedge clk); #2;
         checks++;
         if (count !== 4'(exp_cnt[i]) || co !== exp_co[i]) begin
            errors++;
            $display("FAIL down_step[%0d]: got count=%0d co=%b expected count=%0d co=%b",
                     i, count, co, exp_cnt[i], exp_co[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_load();
      logic [3:0] lvs     [3];
      int         exp_cnt [3];
      bit         exp_t_l [3];
      lvs     = '{4'd3, 4'd9, 4'd0};
      exp_cnt = '{3, 5, 0};
      exp_t_l = '{0, 0, 1};
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 1, 1, lvs[i]);
         #1;
         checks++;
         if (tc !== exp_t_l[i]) begin
            errors++;
            $display("FAIL load_tc[%0d]: got %b expected %b", i, tc, exp_t_l[i]);
         end
         @(posedge clk); #2;
         checks++;
         if (count !== 4'(exp_cnt[i]) || co !== 1'b0) begin
            errors++;
            $display("FAIL load_val[%0d]: got count=%0d co=%b expected count=%0d co=0",
                     i, count, co, exp_cnt[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_hold();
      apply(0, 1, 0, 1, 4'd5);
      @(negedge clk);
      apply(0, 0, 1, 1, 4'd0);
      @(posedge clk); #2;
      checks++;
      if (count !== 4'd0 || co !== 1'b1) begin
         errors++;
         $display("FAIL hold_wrap: got count=%0d co=%b expected count=0 co=1", count, co);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 1, 4'd0);
         #1;
         checks++;
         if (tc !== 1'b0) begin
            errors++;
            $display("FAIL hold_tc[%0d]: got %b expected 0", i, tc);
         end
         @(posedge clk); #2;
         checks++;
         if (count !== 4'd0 || co !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle[%0d]: got count=%0d co=%b expected count=0 co=0", i, count, co);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_priority();
      apply(0, 1, 0, 1, 4'd5);
      @(negedge clk);
      apply(1, 1, 1, 1, 4'd2);
      #1;
      checks++;
      if (tc !== 1'b1) begin
         errors++;
         $display("FAIL rstprio_tc: got %b expected 1", tc);
      end
      @(posedge clk); #2;
      checks++;
      if (count !== 4'd0 || co !== 1'b0) begin
         errors++;
         $display("FAIL rstprio_state: got count=%0d co=%b expected count=0 co=0", count, co);
      end
      @(negedge clk);
   endtask

   task automatic test_full_range();
      apply(0, 1, 0, 1, 4'd7);
      @(negedge clk);
      apply(0, 0, 1, 1, 4'd0);
      #1;
      checks++;
      if (f_tc !== 1'b1) begin
         errors++;
         $display("FAIL full_tc_up: got %b expected 1", f_tc);
      end
      @(posedge clk); #2;
      checks++;
      if (f_cnt !== 3'd0 || f_co !== 1'b1) begin
         errors++;
         $display("FAIL full_wrap_up: got count=%0d co=%b expected count=0 co=1", f_cnt, f_co);
      end
      @(negedge clk);
      apply(0, 0, 1, 0, 4'd0);
      #1;
      checks++;
      if (f_tc !== 1'b1) begin
         errors++;
         $display("FAIL full_tc_down: got %b expected 1", f_tc);
      end
      @(posedge clk); #2;
      checks++;
      if (f_cnt !== 3'd7 || f_co !== 1'b1) begin
         errors++;
         $display("FAIL full_wrap_down: got count=%0d co=%b expected count=7 co=1", f_cnt, f_co);
      end
      @(negedge clk);
   endtask

   task automatic test_direction_random();
      bit r, l, e, u;
      logic [3:0] lv;
      for (int i = 0; i < 80; i++) begin
         r  = ($urandom_range(0, 19) == 0);
         l  = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 1) == 1);
         lv = 4'($urandom_range(0, 15));
         apply(r, l, e, u, lv);
         #1;
         checks++;
         if (tc !== exp_tc || f_tc !== exp_ftc) begin
            errors++;
            $display("FAIL rand_tc[%0d]: got tc=%b ftc=%b expected tc=%b ftc=%b",
                     i, tc, f_tc, exp_tc, exp_ftc);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_cascade();
      int pulses;
      int val;
      pulses = 0;
      rst = 1'b0; load = 1'b0; en = 1'b0;
      c_rst = 1'b1; c_en = 1'b0;
      @(negedge clk);
      c_rst = 1'b0; c_en = 1'b1;
      checks++;
      if (lo_cnt !== 4'd0 || hi_cnt !== 3'd0) begin
         errors++;
         $display("FAIL casc_reset: got %0d%0d expected 00", hi_cnt, lo_cnt);
      end
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #2;
         val = int'(hi_cnt) * 10 + int'(lo_cnt);
         if (hi_co === 1'b1) pulses++;
         checks++;
         if (val !== (i + 1) % 60 || hi_co !== (i == 59)) begin
            errors++;
            $display("FAIL casc_step[%0d]: got value=%0d hi_co=%b expected value=%0d hi_co=%b",
                     i, val, hi_co, (i + 1) % 60, (i == 59));
         end
         @(negedge clk);
      end
      c_en = 1'b0;
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL casc_pulses: got %0d expected 1", pulses);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
      c_rst = 1'b1; c_en = 1'b0;
      @(negedge clk);
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_hold();
      test_reset_priority();
      test_full_range();
      test_direction_random();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending entries expected 0", exp_q.size());
      end
      test_cascade();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
